// File: rtl/amm_port_arbiter_if.sv
// Bus bundle between the two command sources, the arbiter and the AMM slave.
// The slave modport is the arbiter's view; master is the environment driving it.
interface amm_port_arbiter_if #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int BURST_W = 11
);
    localparam int BE_W = DATA_W / 8;

    logic [1:0]              rq_valid_i;
    logic [1:0]              rq_ready_o;
    logic [1:0]              rq_write_i;
    logic [1:0][ADDR_W-1:0]  rq_address_i;
    logic [1:0][BURST_W-1:0] rq_burstcount_i;
    logic [1:0][DATA_W-1:0]  rq_writedata_i;
    logic [1:0][BE_W-1:0]    rq_byteenable_i;
    logic [1:0]              rsp_valid_o;
    logic [DATA_W-1:0]       rsp_data_o;
    logic [ADDR_W-1:0]       amm_address_o;
    logic                    amm_read_o;
    logic                    amm_write_o;
    logic [BURST_W-1:0]      amm_burstcount_o;
    logic [DATA_W-1:0]       amm_writedata_o;
    logic [BE_W-1:0]         amm_byteenable_o;
    logic                    amm_waitrequest_i;
    logic [DATA_W-1:0]       amm_readdata_i;
    logic                    amm_readdatavalid_i;

    modport slave (
        input  rq_valid_i, rq_write_i, rq_address_i, rq_burstcount_i,
        input  rq_writedata_i, rq_byteenable_i,
        input  amm_waitrequest_i, amm_readdata_i, amm_readdatavalid_i,
        output rq_ready_o, rsp_valid_o, rsp_data_o,
        output amm_address_o, amm_read_o, amm_write_o, amm_burstcount_o,
        output amm_writedata_o, amm_byteenable_o
    );

    modport master (
        output rq_valid_i, rq_write_i, rq_address_i, rq_burstcount_i,
        output rq_writedata_i, rq_byteenable_i,
        output amm_waitrequest_i, amm_readdata_i, amm_readdatavalid_i,
        input  rq_ready_o, rsp_valid_o, rsp_data_o,
        input  amm_address_o, amm_read_o, amm_write_o, amm_burstcount_o,
        input  amm_writedata_o, amm_byteenable_o
    );
endinterface

// File: rtl/amm_port_arbiter.sv
// Two-requester Avalon-MM arbiter: burst-granular grants, write-burst locking,
// and a tag FIFO that routes each returning read beat to the requester that issued it.
module amm_port_arbiter #(
    parameter int ADDR_W        = 28,
    parameter int DATA_W        = 128,
    parameter int BURST_W       = 11,
    parameter int RD_FIFO_DEPTH = 16,
    parameter int FIXED_PRIO    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    amm_port_arbiter_if.slave bus,
    output logic              busy_o,
    output logic              orphan_err_o
);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int BE_W  = DATA_W / 8;
    localparam logic [BURST_W-1:0] ONE_C = {{(BURST_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_WR_BURST = 2'd2
    } state_t;

    // A burstcount of zero is handled as a single beat.
    function automatic logic [BURST_W-1:0] eff_len(input logic [BURST_W-1:0] bc);
        return (bc == {BURST_W{1'b0}}) ? ONE_C : bc;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic               r_owner;
    logic               w_owner_next;
    logic               r_rr_ptr;
    logic [BURST_W-1:0] r_wr_left;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [BURST_W-1:0] r_wr_bc;

    logic               r_fifo_id  [RD_FIFO_DEPTH];
    logic [BURST_W-1:0] r_fifo_len [RD_FIFO_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [BURST_W-1:0] r_rd_left;
    logic               r_rd_active;
    logic [1:0]         r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_orphan;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_push;
    logic               w_pop;
    logic               w_load_wr;
    logic               w_wr_dec;
    logic               w_head_id;
    logic [BURST_W-1:0] w_head_len;
    logic [BURST_W-1:0] w_rd_len;
    logic [BURST_W-1:0] w_owner_len;
    logic [1:0]         w_ready;
    logic               w_amm_read;
    logic               w_amm_write;
    logic [ADDR_W-1:0]  w_amm_addr;
    logic [BURST_W-1:0] w_amm_bc;
    logic [DATA_W-1:0]  w_amm_wd;
    logic [BE_W-1:0]    w_amm_be;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head_id    = r_fifo_id[r_rd_ptr[PTR_W-1:0]];
    assign w_head_len   = r_fifo_len[r_rd_ptr[PTR_W-1:0]];
    assign w_rd_len     = r_rd_active ? r_rd_left : w_head_len;
    assign w_pop        = bus.amm_readdatavalid_i && !w_fifo_empty && (w_rd_len == ONE_C);
    assign w_owner_len  = eff_len(bus.rq_burstcount_i[r_owner]);

    // Arbitration and owner-to-AMM request steering.
    always_comb begin
        w_next_state = r_state;
        w_owner_next = r_owner;
        w_ready      = 2'b00;
        w_amm_read   = 1'b0;
        w_amm_write  = 1'b0;
        w_amm_addr   = {ADDR_W{1'b0}};
        w_amm_bc     = {BURST_W{1'b0}};
        w_amm_wd     = {DATA_W{1'b0}};
        w_amm_be     = {BE_W{1'b0}};
        w_push       = 1'b0;
        w_load_wr    = 1'b0;
        w_wr_dec     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rq_valid_i != 2'b00) begin
                    w_next_state = ST_GRANT;
                    if (bus.rq_valid_i == 2'b11) begin
                        w_owner_next = (FIXED_PRIO != 0) ? 1'b0 : r_rr_ptr;
                    end else begin
                        w_owner_next = bus.rq_valid_i[1];
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GRANT: begin
                w_amm_addr = bus.rq_address_i[r_owner];
                w_amm_bc   = bus.rq_burstcount_i[r_owner];
                w_amm_wd   = bus.rq_writedata_i[r_owner];
                w_amm_be   = bus.rq_byteenable_i[r_owner];
                if (bus.rq_write_i[r_owner]) begin
                    w_amm_write      = bus.rq_valid_i[r_owner];
                    w_ready[r_owner] = !bus.amm_waitrequest_i;
                    if (bus.rq_valid_i[r_owner] && !bus.amm_waitrequest_i) begin
                        w_load_wr    = 1'b1;
                        w_next_state = (w_owner_len == ONE_C) ? ST_IDLE : ST_WR_BURST;
                    end else begin
                        w_next_state = ST_GRANT;
                    end
                end else begin
                    // A full tag FIFO holds the read off the bus entirely.
                    w_amm_read       = bus.rq_valid_i[r_owner] && !w_fifo_full;
                    w_ready[r_owner] = !bus.amm_waitrequest_i && !w_fifo_full;
                    if (w_amm_read && !bus.amm_waitrequest_i) begin
                        w_push       = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_GRANT;
                    end
                end
            end
            ST_WR_BURST: begin
                w_amm_addr       = r_wr_addr;
                w_amm_bc         = r_wr_bc;
                w_amm_wd         = bus.rq_writedata_i[r_owner];
                w_amm_be         = bus.rq_byteenable_i[r_owner];
                w_amm_write      = bus.rq_valid_i[r_owner];
                w_ready[r_owner] = !bus.amm_waitrequest_i;
                if (bus.rq_valid_i[r_owner] && !bus.amm_waitrequest_i) begin
                    w_wr_dec     = 1'b1;
                    w_next_state = (r_wr_left == ONE_C) ? ST_IDLE : ST_WR_BURST;
                end else begin
                    w_next_state = ST_WR_BURST;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, owner, round-robin pointer and write-burst bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_wr_left <= {BURST_W{1'b0}};
            r_wr_addr <= {ADDR_W{1'b0}};
            r_wr_bc   <= {BURST_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_owner <= w_owner_next;
            if ((r_state != ST_IDLE) && (w_next_state == ST_IDLE)) begin
                r_rr_ptr <= ~r_owner;
            end
            if (w_load_wr) begin
                r_wr_left <= w_owner_len - ONE_C;
                r_wr_addr <= bus.rq_address_i[r_owner];
                r_wr_bc   <= bus.rq_burstcount_i[r_owner];
            end else if (w_wr_dec) begin
                r_wr_left <= r_wr_left - ONE_C;
            end
        end
    end

    // Tag storage; entries are only read while the pointers say they are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr[PTR_W-1:0]]  <= r_owner;
            r_fifo_len[r_wr_ptr[PTR_W-1:0]] <= w_owner_len;
        end
    end

    // Tag pointers, read-beat routing and orphan detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= {(PTR_W+1){1'b0}};
            r_rd_ptr    <= {(PTR_W+1){1'b0}};
            r_rd_left   <= {BURST_W{1'b0}};
            r_rd_active <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= {DATA_W{1'b0}};
            r_orphan    <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (bus.amm_readdatavalid_i && !w_fifo_empty) begin
                r_rsp_valid[w_head_id] <= 1'b1;
                r_rsp_data             <= bus.amm_readdata_i;
                if (w_pop) begin
                    r_rd_ptr    <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
                    r_rd_active <= 1'b0;
                end else begin
                    r_rd_left   <= w_rd_len - ONE_C;
                    r_rd_active <= 1'b1;
                end
            end else if (bus.amm_readdatavalid_i) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign bus.rq_ready_o       = w_ready;
    assign bus.amm_read_o       = w_amm_read;
    assign bus.amm_write_o      = w_amm_write;
    assign bus.amm_address_o    = w_amm_addr;
    assign bus.amm_burstcount_o = w_amm_bc;
    assign bus.amm_writedata_o  = w_amm_wd;
    assign bus.amm_byteenable_o = w_amm_be;
    assign bus.rsp_valid_o      = r_rsp_valid;
    assign bus.rsp_data_o       = r_rsp_data;
    assign busy_o               = (r_state != ST_IDLE) || !w_fifo_empty;
    assign orphan_err_o         = r_orphan;
endmodule

// File: tb/tb_amm_port_arbiter.sv
// Directed bench for amm_port_arbiter: each task drives one scenario and checks
// hand-computed expectations inline. Inputs change on the falling edge; outputs sampled 1 ns later.
module tb_amm_port_arbiter;
    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 128;
    localparam int BURST_W = 11;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic busy_o;
    logic orphan_err_o;
    int   n_checks = 0;
    int   n_errors = 0;

    amm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

    amm_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .RD_FIFO_DEPTH(16), .FIXED_PRIO(0)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .orphan_err_o(orphan_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DATA_W-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(k);
        return {4{w}};
    endfunction

    task automatic clear_inputs();
        bus.rq_valid_i          = 2'b00;
        bus.rq_write_i          = 2'b00;
        bus.rq_address_i        = '0;
        bus.rq_burstcount_i     = '0;
        bus.rq_writedata_i      = '0;
        bus.rq_byteenable_i     = '0;
        bus.amm_waitrequest_i   = 1'b0;
        bus.amm_readdata_i      = '0;
        bus.amm_readdatavalid_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Stimulus only: presents a read and waits (bounded) for its acceptance.
    task automatic issue_read(input int id, input logic [ADDR_W-1:0] a,
                              input logic [BURST_W-1:0] bc, output bit ok);
        ok = 1'b0;
        bus.rq_valid_i          = 2'b00;
        bus.rq_valid_i[id]      = 1'b1;
        bus.rq_write_i[id]      = 1'b0;
        bus.rq_address_i[id]    = a;
        bus.rq_burstcount_i[id] = bc;
        for (int c = 0; c < 40; c++) begin
            logic acc;
            #1;
            acc = bus.rq_ready_o[id] && bus.amm_read_o;
            @(negedge clk_i);
            if (acc) begin
                bus.rq_valid_i = 2'b00;
                ok = 1'b1;
                break;
            end
        end
        bus.rq_valid_i = 2'b00;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_i = 1'b1;
        bus.rq_valid_i          = 2'b11;
        bus.amm_readdatavalid_i = 1'b1;
        @(negedge clk_i); #1;
        n_checks++; if (bus.rq_ready_o !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b expected 00", bus.rq_ready_o); end
        n_checks++; if (bus.amm_read_o !== 1'b0 || bus.amm_write_o !== 1'b0) begin n_errors++; $display("FAIL reset_rw: got rd=%b wr=%b expected 0/0", bus.amm_read_o, bus.amm_write_o); end
        n_checks++; if (bus.amm_address_o !== 28'h0 || bus.amm_burstcount_o !== 11'd0) begin n_errors++; $display("FAIL reset_addr: got %h/%0d expected 0/0", bus.amm_address_o, bus.amm_burstcount_o); end
        n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_errors++; $display("FAIL reset_rsp: got %b expected 00", bus.rsp_valid_o); end
        n_checks++; if (busy_o !== 1'b0 || orphan_err_o !== 1'b0) begin n_errors++; $display("FAIL reset_status: got busy=%b orphan=%b expected 0/0", busy_o, orphan_err_o); end
        clear_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_release_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_write_burst();
        int   beats;
        logic wt;
        logic drop;
        do_reset();
        bus.rq_write_i         = 2'b01;
        bus.rq_valid_i         = 2'b01;
        bus.rq_address_i[0]    = 28'h100;
        bus.rq_burstcount_i[0] = 11'd4;
        bus.rq_writedata_i[0]  = pat(0);
        bus.rq_byteenable_i[0] = 16'hFFFF;
        #1;
        n_checks++; if (bus.rq_ready_o !== 2'b00 || bus.amm_write_o !== 1'b0) begin n_errors++; $display("FAIL wr_bubble: got ready=%b wr=%b expected 00/0", bus.rq_ready_o, bus.amm_write_o); end
        beats = 0;
        for (int c = 0; c < 24 && beats < 4; c++) begin
            @(negedge clk_i);
            drop = (c == 3);
            wt   = (c % 2 == 0);
            bus.rq_valid_i        = {1'b1, !drop};
            bus.amm_waitrequest_i = wt;
            bus.rq_writedata_i[0] = pat(beats);
            #1;
            n_checks++; if (bus.amm_write_o !== !drop) begin n_errors++; $display("FAIL wr_write c%0d: got %b expected %b", c, bus.amm_write_o, !drop); end
            n_checks++; if (bus.rq_ready_o !== {1'b0, !wt}) begin n_errors++; $display("FAIL wr_ready c%0d: got %b expected %b", c, bus.rq_ready_o, {1'b0, !wt}); end
            if (!drop) begin
                n_checks++; if (bus.amm_address_o !== 28'h100 || bus.amm_burstcount_o !== 11'd4) begin n_errors++; $display("FAIL wr_addr c%0d: got %h/%0d expected 100/4", c, bus.amm_address_o, bus.amm_burstcount_o); end
                n_checks++; if (bus.amm_writedata_o !== pat(beats)) begin n_errors++; $display("FAIL wr_data c%0d: got %h expected %h", c, bus.amm_writedata_o, pat(beats)); end
            end
            if (!drop && !wt) beats++;
        end
        @(negedge clk_i);
        bus.rq_valid_i        = 2'b00;
        bus.amm_waitrequest_i = 1'b0;
        #1;
        n_checks++; if (beats !== 4) begin n_errors++; $display("FAIL wr_beats: got %0d expected 4", beats); end
        n_checks++; if (bus.amm_write_o !== 1'b0 || busy_o !== 1'b0) begin n_errors++; $display("FAIL wr_end_idle: got wr=%b busy=%b expected 0/0", bus.amm_write_o, busy_o); end
    endtask

    task automatic test_rr_reads();
        int exp_id;
        do_reset();
        bus.rq_write_i         = 2'b00;
        bus.rq_address_i[0]    = 28'h0A0;
        bus.rq_address_i[1]    = 28'h0B0;
        bus.rq_burstcount_i[0] = 11'd1;
        bus.rq_burstcount_i[1] = 11'd1;
        bus.rq_valid_i         = 2'b11;
        for (int r = 0; r < 6; r++) begin
            exp_id = r % 2;
            #1;
            n_checks++; if (bus.rq_ready_o !== 2'b00 || bus.amm_read_o !== 1'b0) begin n_errors++; $display("FAIL rr_bubble r%0d: got ready=%b rd=%b expected 00/0", r, bus.rq_ready_o, bus.amm_read_o); end
            @(negedge clk_i); #1;
            n_checks++; if (bus.rq_ready_o !== ((exp_id == 1) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL rr_grant r%0d: got %b expected owner %0d", r, bus.rq_ready_o, exp_id); end
            n_checks++; if (bus.amm_read_o !== 1'b1 || bus.amm_address_o !== ((exp_id == 1) ? 28'h0B0 : 28'h0A0)) begin n_errors++; $display("FAIL rr_addr r%0d: got rd=%b addr=%h", r, bus.amm_read_o, bus.amm_address_o); end
            @(negedge clk_i);
        end
        bus.rq_valid_i = 2'b00;
        for (int k = 0; k < 7; k++) begin
            bus.amm_readdatavalid_i = (k < 6);
            bus.amm_readdata_i      = pat(100 + k);
            #1;
            if (k > 0) begin
                n_checks++; if (bus.rsp_valid_o !== (((k - 1) % 2 == 1) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL rr_route k%0d: got %b", k, bus.rsp_valid_o); end
                n_checks++; if (bus.rsp_data_o !== pat(100 + k - 1)) begin n_errors++; $display("FAIL rr_data k%0d: got %h expected %h", k, bus.rsp_data_o, pat(100 + k - 1)); end
            end
            @(negedge clk_i);
        end
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin n_errors++; $display("FAIL rr_drained: got rsp=%b busy=%b expected 00/0", bus.rsp_valid_o, busy_o); end
    endtask

    task automatic test_read_routing();
        bit ok;
        do_reset();
        issue_read(1, 28'h200, 11'd8, ok);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL route_issue1: got %b expected 1", ok); end
        issue_read(0, 28'h300, 11'd2, ok);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL route_issue0: got %b expected 1", ok); end
        for (int k = 0; k < 11; k++) begin
            bus.amm_readdatavalid_i = (k < 10);
            bus.amm_readdata_i      = pat(200 + k);
            #1;
            if (k > 0) begin
                n_checks++; if (bus.rsp_valid_o !== ((k - 1 < 8) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL route_valid beat%0d: got %b", k, bus.rsp_valid_o); end
                n_checks++; if (bus.rsp_data_o !== pat(200 + k - 1)) begin n_errors++; $display("FAIL route_data beat%0d: got %h expected %h", k, bus.rsp_data_o, pat(200 + k - 1)); end
            end
            @(negedge clk_i);
        end
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin n_errors++; $display("FAIL route_end: got rsp=%b busy=%b expected 00/0", bus.rsp_valid_o, busy_o); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int n_ok;
        do_reset();
        n_ok = 0;
        for (int i = 0; i < 16; i++) begin
            issue_read(0, 28'h400 + 28'(i), 11'd1, ok);
            if (ok) n_ok++;
        end
        n_checks++; if (n_ok !== 16) begin n_errors++; $display("FAIL full_fill: got %0d accepted expected 16", n_ok); end
        bus.rq_valid_i         = 2'b01;
        bus.rq_write_i         = 2'b00;
        bus.rq_address_i[0]    = 28'h4FF;
        bus.rq_burstcount_i[0] = 11'd1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (bus.amm_read_o !== 1'b0 || bus.rq_ready_o !== 2'b00) begin n_errors++; $display("FAIL full_hold c%0d: got rd=%b ready=%b expected 0/00", c, bus.amm_read_o, bus.rq_ready_o); end
            @(negedge clk_i);
        end
        bus.amm_readdatavalid_i = 1'b1;
        bus.amm_readdata_i      = pat(300);
        #1;
        n_checks++; if (bus.amm_read_o !== 1'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL full_pop_cycle: got rd=%b busy=%b expected 0/1", bus.amm_read_o, busy_o); end
        @(negedge clk_i);
        bus.amm_readdatavalid_i = 1'b0;
        #1;
        n_checks++; if (bus.amm_read_o !== 1'b1 || bus.rq_ready_o !== 2'b01 || bus.amm_address_o !== 28'h4FF) begin n_errors++; $display("FAIL full_accept17: got rd=%b ready=%b addr=%h expected 1/01/4ff", bus.amm_read_o, bus.rq_ready_o, bus.amm_address_o); end
        n_checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== pat(300)) begin n_errors++; $display("FAIL full_first_rsp: got %b/%h", bus.rsp_valid_o, bus.rsp_data_o); end
        @(negedge clk_i);
        bus.rq_valid_i = 2'b00;
        for (int k = 0; k < 17; k++) begin
            bus.amm_readdatavalid_i = (k < 16);
            bus.amm_readdata_i      = pat(400 + k);
            #1;
            if (k > 0) begin
                n_checks++; if (bus.rsp_valid_o !== 2'b01) begin n_errors++; $display("FAIL full_drain k%0d: got %b expected 01", k, bus.rsp_valid_o); end
            end
            @(negedge clk_i);
        end
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL full_empty_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_orphan();
        do_reset();
        bus.amm_readdatavalid_i = 1'b1;
        bus.amm_readdata_i      = pat(9);
        @(negedge clk_i);
        bus.amm_readdatavalid_i = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_errors++; $display("FAIL orphan_rsp: got %b expected 00", bus.rsp_valid_o); end
        n_checks++; if (orphan_err_o !== 1'b1 || busy_o !== 1'b0) begin n_errors++; $display("FAIL orphan_set: got orphan=%b busy=%b expected 1/0", orphan_err_o, busy_o); end
        repeat (3) @(negedge clk_i);
        #1;
        n_checks++; if (orphan_err_o !== 1'b1) begin n_errors++; $display("FAIL orphan_sticky: got %b expected 1", orphan_err_o); end
        rst_i = 1'b1;
        #1;
        n_checks++; if (orphan_err_o !== 1'b0) begin n_errors++; $display("FAIL orphan_clear: got %b expected 0", orphan_err_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.rq_write_i         = 2'b01;
        bus.rq_valid_i         = 2'b01;
        bus.rq_address_i[0]    = 28'h700;
        bus.rq_burstcount_i[0] = 11'd4;
        bus.rq_writedata_i[0]  = pat(0);
        @(negedge clk_i);
        @(negedge clk_i);
        bus.rq_writedata_i[0] = pat(1);
        #1;
        n_checks++; if (bus.amm_write_o !== 1'b1 || busy_o !== 1'b1) begin n_errors++; $display("FAIL rstb_beat2: got wr=%b busy=%b expected 1/1", bus.amm_write_o, busy_o); end
        rst_i = 1'b1;
        #1;
        n_checks++; if (bus.amm_write_o !== 1'b0 || bus.rq_ready_o !== 2'b00 || busy_o !== 1'b0) begin n_errors++; $display("FAIL rstb_outputs: got wr=%b ready=%b busy=%b expected 0/00/0", bus.amm_write_o, bus.rq_ready_o, busy_o); end
        n_checks++; if (bus.amm_address_o !== 28'h0 || bus.amm_burstcount_o !== 11'd0) begin n_errors++; $display("FAIL rstb_addr: got %h/%0d expected 0/0", bus.amm_address_o, bus.amm_burstcount_o); end
        @(negedge clk_i);
        clear_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        bus.rq_valid_i         = 2'b10;
        bus.rq_write_i         = 2'b00;
        bus.rq_address_i[1]    = 28'h055;
        bus.rq_burstcount_i[1] = 11'd1;
        #1;
        n_checks++; if (bus.rq_ready_o !== 2'b00) begin n_errors++; $display("FAIL rstb_new_bubble: got %b expected 00", bus.rq_ready_o); end
        @(negedge clk_i); #1;
        n_checks++; if (bus.amm_read_o !== 1'b1 || bus.rq_ready_o !== 2'b10 || bus.amm_address_o !== 28'h055) begin n_errors++; $display("FAIL rstb_new_grant: got rd=%b ready=%b addr=%h expected 1/10/055", bus.amm_read_o, bus.rq_ready_o, bus.amm_address_o); end
        @(negedge clk_i);
        bus.rq_valid_i          = 2'b00;
        bus.amm_readdatavalid_i = 1'b1;
        bus.amm_readdata_i      = pat(77);
        @(negedge clk_i);
        bus.amm_readdatavalid_i = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_data_o !== pat(77) || busy_o !== 1'b0) begin n_errors++; $display("FAIL rstb_new_rsp: got %b/%h busy=%b", bus.rsp_valid_o, bus.rsp_data_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_rr_reads();
        test_read_routing();
        test_fifo_full();
        test_orphan();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
